// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory access per instruction over a
// req/gnt/rvalid bus. It aligns and extends load data, and flags
// misaligned, illegal or timed-out accesses.
// Ports:
//   clk, reset          clock, async active-high reset
//   req_*               memory instruction from execute (held until done)
//   busy                combinational stall to the core
//   done                one-cycle completion pulse
//   misaligned/bus_err  status, valid with done
//   load_data           extended load result, held until the next load done
//   mem_*               data bus master side
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         lane_q, lane_d;
  logic               mem_req_d, mem_we_d, done_d, mis_d, err_d;
  logic [31:0]        mem_addr_d, mem_wdata_d, load_data_d;
  logic [3:0]         mem_be_d;
  logic               illegal_c, misal_c, tmo_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c, rdata_ext_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;

  assign busy = req_valid & ~done;

  // Request decode: legality, alignment, byte enables, lane replication
  always_comb begin
    illegal_c = req_we ? (req_funct3 >= 3'd3)
                       : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    misal_c   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_funct3[1:0])
      2'b00:   begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01:   begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  // Load extraction from the captured lane and funct3
  always_comb begin
    byte_c = mem_rdata[{lane_q, 3'b000} +: 8];
    half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  rdata_ext_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  rdata_ext_c = {{16{half_c[15]}}, half_c};
      3'b100:  rdata_ext_c = {24'd0, byte_c};
      3'b101:  rdata_ext_c = {16'd0, half_c};
      default: rdata_ext_c = mem_rdata;
    endcase
  end

  // The last waiting cycle in REQ or WAIT before giving up
  assign tmo_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next state and next registered outputs
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    f3_d        = f3_q;
    lane_d      = lane_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    load_data_d = load_data;
    done_d      = 1'b0;
    mis_d       = 1'b0;
    err_d       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal_c || misal_c) begin
            state_d     = DONE;
            done_d      = 1'b1;
            err_d       = illegal_c;
            mis_d       = ~illegal_c;
            load_data_d = 32'd0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            cnt_d       = '0;
            f3_d        = req_funct3;
            lane_d      = req_addr[1:0];
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = wdata_c;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (mem_we) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else if (tmo_c) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          cnt_d     = cnt + CNT_W'(1);
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d     = DONE;
          done_d      = 1'b1;
          load_data_d = rdata_ext_c;
        end else if (tmo_c) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_q       <= 3'd0;
      lane_q     <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      load_data  <= 32'd0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      f3_q       <= f3_d;
      lane_q     <= lane_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_be     <= mem_be_d;
      mem_wdata  <= mem_wdata_d;
      load_data  <= load_data_d;
      done       <= done_d;
      misaligned <= mis_d;
      bus_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed transactions against a small
// transaction-level model, plus literal expectations for key cases.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, misaligned, bus_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  // Current transaction as seen by the model
  logic        c_we = 1'b0;
  logic [2:0]  c_f3 = 3'd0;
  logic [31:0] c_addr = 32'd0, c_wdata = 32'd0, c_rdata = 32'd0;
  logic        c_to = 1'b0;
  logic [31:0] m_ld = 32'd0;

  // Values captured by the driver during the last transaction
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_mis, cap_err;
  int          lat, reqc;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 = goes to the bus, 1 = misaligned, 2 = illegal funct3
  function automatic int m_class(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2;
    if ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0)) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned ofs;
    ofs = int'(a[1:0]);
    if (f3[1:0] == 2'd0) return 4'(1 << ofs);
    if (f3[1:0] == 2'd1) return (ofs >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] b, h;
    b = d & 32'hFF;
    h = d & 32'hFFFF;
    if (f3[1:0] == 2'd0) return b * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return h * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int unsigned ofs;
    logic [31:0] b, h;
    ofs = int'(a[1:0]);
    b = (d >> (8 * ofs)) & 32'hFF;
    h = (d >> ((ofs >= 2) ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int cls;
    logic [31:0] exp_ld;
    if (!reset) begin
      chk("busy", 32'(busy), 32'(req_valid && !done));
      cls = m_class(c_we, c_f3, c_addr);
      if (mem_req) begin
        chk("req_legal", 32'(cls), 32'd0);
        chk("mem_addr", mem_addr, c_addr & 32'hFFFF_FFFC);
        chk("mem_we", 32'(mem_we), 32'(c_we));
        chk("mem_be", 32'(mem_be), 32'(m_be(c_f3, c_addr)));
        if (c_we) chk("mem_wdata", mem_wdata, m_wdata(c_f3, c_wdata));
      end
      if (done) begin
        chk("req_at_done", 32'(mem_req), 32'd0);
        chk("misaligned", 32'(misaligned), 32'(cls == 1));
        chk("bus_err", 32'(bus_err), 32'(cls == 2 || (cls == 0 && c_to)));
        if (cls != 0)           exp_ld = 32'd0;
        else if (c_to || c_we)  exp_ld = m_ld;
        else                    exp_ld = m_load(c_f3, c_addr, c_rdata);
        chk("load_data", load_data, exp_ld);
        m_ld = exp_ld;
      end
    end
  end

  // One transaction; gd/rd are grant/rvalid wait cycles, negative = never
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input int gd, input int rd);
    int gc, rc;
    logic gs, rs;
    c_we = we; c_f3 = f3; c_addr = addr; c_wdata = wdata; c_rdata = rdata;
    c_to = (gd < 0) || (!we && rd < 0);
    cap_addr = 32'd0; cap_wdata = 32'd0; cap_be = 4'd0; cap_mis = 1'b0; cap_err = 1'b0;
    lat = -1; reqc = 0; gc = 0; rc = 0; gs = 1'b0; rs = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (done) begin
        lat = i; cap_mis = misaligned; cap_err = bus_err;
        break;
      end
      if (mem_req) begin
        reqc++; cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata;
      end
      if (gs && !we && !rs && rd >= 0) begin
        if (rc == rd) begin
          mem_rvalid = 1'b1; mem_rdata = rdata; rs = 1'b1;
        end else rc++;
      end
      if (mem_req && !gs && gd >= 0) begin
        if (gc == gd) begin
          mem_gnt = 1'b1; gs = 1'b1;
        end else gc++;
      end
    end
    if (lat < 0) chk("done_wait_expired", 32'd0, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk); @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(1'b0, 3'd0, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 0);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_addr", cap_addr, 32'h0000_1000);
    chk("lb_be", 32'(cap_be), 32'h8);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    run(1'b0, 3'd4, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 0);
    chk("lbu_data", load_data, 32'h0000_0080);
    run(1'b0, 3'd5, 32'h0000_1002, 32'd0, 32'h80FF_1234, 0, 0);
    chk("lhu_data", load_data, 32'h0000_80FF);
    run(1'b0, 3'd1, 32'h0000_1002, 32'd0, 32'h80FF_1234, 0, 0);
    chk("lh_data", load_data, 32'hFFFF_80FF);

    run(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 3, 0);
    chk("sh_reqc", 32'(reqc), 32'd4);
    chk("sh_lat", 32'(lat), 32'd5);
    chk("sh_addr", cap_addr, 32'h0000_2000);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_keeps_ld", load_data, 32'hFFFF_80FF);

    run(1'b1, 3'd0, 32'h0000_3001, 32'h0000_55AA, 32'd0, 1, 0);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hAAAA_AAAA);

    run(1'b0, 3'd2, 32'h0000_1000, 32'd0, 32'hCAFE_F00D, 0, 2);
    chk("lw_lat", 32'(lat), 32'd5);
    chk("lw_data", load_data, 32'hCAFE_F00D);

    run(1'b1, 3'd2, 32'h0000_0020, 32'h1111_2222, 32'd0, -1, 0);
    chk("tmo_gnt_reqc", 32'(reqc), 32'd4);
    chk("tmo_gnt_lat", 32'(lat), 32'd5);
    chk("tmo_gnt_err", 32'(cap_err), 32'd1);
    chk("tmo_gnt_ld", load_data, 32'hCAFE_F00D);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray_rv_done", 32'(done), 32'd0);
    chk("stray_rv_ld", load_data, 32'hCAFE_F00D);

    run(1'b0, 3'd2, 32'h0000_0040, 32'd0, 32'h0BAD_0BAD, 0, -1);
    chk("tmo_rv_lat", 32'(lat), 32'd6);
    chk("tmo_rv_err", 32'(cap_err), 32'd1);
    chk("tmo_rv_ld", load_data, 32'hCAFE_F00D);

    // Reset asserted between edges while waiting for read data
    c_we = 1'b0; c_f3 = 3'd2; c_addr = 32'h0000_0100; c_to = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0100;
    @(negedge clk);
    chk("mid_req_up", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("mid_wait_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ld", load_data, 32'd0);
    chk("mid_rst_be", 32'(mem_be), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    req_valid = 1'b0;
    m_ld = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 0, 0);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_be", 32'(cap_be), 32'hF);
    chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);

    run(1'b0, 3'd0, 32'h0000_1003, 32'd0, 32'h7F00_0000, 0, 0);
    chk("lb_pos_data", load_data, 32'h0000_007F);
    run(1'b0, 3'd2, 32'h0000_1001, 32'd0, 32'd0, 0, 0);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_reqc", 32'(reqc), 32'd0);
    chk("mis_flag", 32'(cap_mis), 32'd1);
    chk("mis_ld", load_data, 32'd0);
    run(1'b1, 3'd3, 32'h0000_0040, 32'h1, 32'd0, 0, 0);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_reqc", 32'(reqc), 32'd0);
    chk("ill_err", 32'(cap_err), 32'd1);
    run(1'b0, 3'd6, 32'h0000_0000, 32'd0, 32'd0, 0, 0);
    chk("ill_ld_err", 32'(cap_err), 32'd1);
    run(1'b0, 3'd5, 32'h0000_0003, 32'd0, 32'd0, 0, 0);
    chk("lhu_mis_flag", 32'(cap_mis), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
